// File: rtl/dwt_frame_sequencer.sv
// dwt_frame_sequencer: frame-level controller for dwt_module.
// Streams a LENGTH x LENGTH 8-bit image from a synchronous source RAM into
// dwt_module in row-pair bands (3 rows first, 2 rows per middle band, 1 row
// last). Each band's LENGTH s/d result pairs go to a destination RAM: s into
// the top half of the output image and d into the bottom half.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   start                    one-cycle frame start request (ignored while busy)
//   busy, done               frame in progress / one-cycle end-of-frame pulse
//   src_addr, src_rdata      source RAM read port (data one cycle after address)
//   dwt_en, dwt_rdy, dwt_in  band start, ready and sample stream to dwt_module
//   dwt_result, dwt_s, dwt_d result strobe and coefficient pair from dwt_module
//   dst_we, dst_*_addr/data  destination RAM write ports for s and d
module dwt_frame_sequencer #(
    parameter int unsigned LENGTH = 256,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_rdata,
    output logic              dwt_en,
    input  logic              dwt_rdy,
    output logic [7:0]        dwt_in,
    input  logic              dwt_result,
    input  logic [7:0]        dwt_s,
    input  logic [7:0]        dwt_d,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_s_addr,
    output logic [ADDR_W-1:0] dst_d_addr,
    output logic [7:0]        dst_s_data,
    output logic [7:0]        dst_d_data
);

    localparam int unsigned LW = $clog2(LENGTH);
    localparam int unsigned BW = LW - 1;
    localparam int unsigned KW = $clog2(3 * LENGTH) + 1;

    localparam logic [BW-1:0] LAST_BAND = BW'(LENGTH / 2 - 1);
    localparam logic [LW-1:0] LAST_COL  = LW'(LENGTH - 1);
    localparam logic [KW-1:0] N_FIRST   = KW'(3 * LENGTH);
    localparam logic [KW-1:0] N_MID     = KW'(2 * LENGTH);
    localparam logic [KW-1:0] N_LAST    = KW'(LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        FEED,
        WAIT_RES,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dst_we_q, dst_we_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] dst_s_addr_q, dst_s_addr_d;
    logic [ADDR_W-1:0] dst_d_addr_q, dst_d_addr_d;
    logic [7:0]        dwt_in_q, dwt_in_d;
    logic [BW-1:0]     band_q, band_d;
    logic [KW-1:0]     smp_q, smp_d;
    logic [LW-1:0]     col_q, col_d;
    logic [KW-1:0]     band_len;

    // Samples per band: the first band carries an extra row of context,
    // the last band only the single remaining row.
    always_comb begin
        if (band_q == '0) begin
            band_len = N_FIRST;
        end else if (band_q == LAST_BAND) begin
            band_len = N_LAST;
        end else begin
            band_len = N_MID;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dst_we_d     = dst_we_q;
        src_addr_d   = src_addr_q;
        rptr_d       = rptr_q;
        dst_s_addr_d = dst_s_addr_q;
        dst_d_addr_d = dst_d_addr_q;
        dwt_in_d     = dwt_in_q;
        band_d       = band_q;
        smp_d        = smp_q;
        col_d        = col_q;
        dwt_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_RDY;
                    busy_d     = 1'b1;
                    rptr_d     = '0;
                    band_d     = '0;
                    src_addr_d = '0;
                end
            end
            WAIT_RDY: begin
                // src_addr already holds the read pointer, so the first sample
                // arrives from the RAM in the cycle after dwt_en.
                if (dwt_rdy) begin
                    dwt_en     = 1'b1;
                    state_d    = FEED;
                    smp_d      = '0;
                    src_addr_d = rptr_q + ADDR_W'(1);
                end
            end
            FEED: begin
                dwt_in_d = src_rdata;
                if (smp_q == band_len - KW'(1)) begin
                    rptr_d  = rptr_q + ADDR_W'(band_len);
                    state_d = WAIT_RES;
                end else begin
                    smp_d      = smp_q + KW'(1);
                    src_addr_d = rptr_q + ADDR_W'(smp_q) + ADDR_W'(2);
                end
            end
            WAIT_RES: begin
                if (dwt_result) begin
                    state_d      = DRAIN;
                    col_d        = '0;
                    dst_we_d     = 1'b1;
                    dst_s_addr_d = ADDR_W'(band_q) << LW;
                    dst_d_addr_d = ADDR_W'({1'b1, band_q}) << LW;
                end
            end
            DRAIN: begin
                if (col_q == LAST_COL) begin
                    dst_we_d = 1'b0;
                    if (band_q == LAST_BAND) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        band_d  = band_q + BW'(1);
                        state_d = WAIT_RDY;
                    end
                end else begin
                    col_d        = col_q + LW'(1);
                    dst_s_addr_d = dst_s_addr_q + ADDR_W'(1);
                    dst_d_addr_d = dst_d_addr_q + ADDR_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dst_we_q     <= 1'b0;
            src_addr_q   <= '0;
            rptr_q       <= '0;
            dst_s_addr_q <= '0;
            dst_d_addr_q <= '0;
            dwt_in_q     <= '0;
            band_q       <= '0;
            smp_q        <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dst_we_q     <= dst_we_d;
            src_addr_q   <= src_addr_d;
            rptr_q       <= rptr_d;
            dst_s_addr_q <= dst_s_addr_d;
            dst_d_addr_q <= dst_d_addr_d;
            dwt_in_q     <= dwt_in_d;
            band_q       <= band_d;
            smp_q        <= smp_d;
            col_q        <= col_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign src_addr   = src_addr_q;
    assign dst_we     = dst_we_q;
    assign dst_s_addr = dst_s_addr_q;
    assign dst_d_addr = dst_d_addr_q;

    // RAM data goes straight through while feeding; the last sample is held after.
    assign dwt_in = (state_q == FEED) ? src_rdata : dwt_in_q;

    // Coefficients pass straight through, forced to zero outside a drain.
    assign dst_s_data = dst_we_q ? dwt_s : 8'h00;
    assign dst_d_data = dst_we_q ? dwt_d : 8'h00;

endmodule

// File: tb/tb_dwt_frame_sequencer.sv
// Scoreboard bench for dwt_frame_sequencer with LENGTH=8: source RAM holds
// pixel p = p mod 256; a behavioural dwt_module returns s=col, d=band+0x80.
module tb_dwt_frame_sequencer;

    localparam int PH_IDLE  = 0;
    localparam int PH_FEED  = 1;
    localparam int PH_LAT   = 2;
    localparam int PH_OUT   = 3;
    localparam int PH_POST  = 4;
    localparam int PH_STALL = 5;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        dwt_en;
    logic        dwt_rdy;
    logic [7:0]  dwt_in;
    logic        dwt_result;
    logic [7:0]  dwt_s;
    logic [7:0]  dwt_d;
    logic        dst_we;
    logic [15:0] dst_s_addr;
    logic [15:0] dst_d_addr;
    logic [7:0]  dst_s_data;
    logic [7:0]  dst_d_data;

    dwt_frame_sequencer #(.LENGTH(8), .ADDR_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .src_addr(src_addr), .src_rdata(src_rdata),
        .dwt_en(dwt_en), .dwt_rdy(dwt_rdy), .dwt_in(dwt_in),
        .dwt_result(dwt_result), .dwt_s(dwt_s), .dwt_d(dwt_d),
        .dst_we(dst_we), .dst_s_addr(dst_s_addr), .dst_d_addr(dst_d_addr),
        .dst_s_data(dst_s_data), .dst_d_data(dst_d_data)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_seen = 0;
    int exp_done = 0;
    int n_we = 0;
    int n_en_seen = 0;

    int cfg_stall_band = 99;
    int cfg_lat = 0;
    bit cfg_spur = 1'b0;

    int m_ph = PH_IDLE;
    int m_band = 0;
    int m_cnt = 0;
    int m_n = 0;
    logic [15:0] stall_addr;

    logic [7:0]  feed_q[$];
    logic [47:0] exp_q[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous source RAM: word p holds p mod 256.
    initial begin
        logic [15:0] a;
        src_rdata = 8'h00;
        forever begin
            @(negedge clk);
            a = src_addr;
            @(posedge clk);
            #1;
            src_rdata = a[7:0];
        end
    end

    // Behavioural dwt_module: consumes samples, then returns s=col, d=band+0x80.
    initial begin
        logic       n_rdy;
        logic       n_res;
        logic [7:0] n_s;
        logic [7:0] n_d;
        n_rdy = 1'b1;
        dwt_rdy = 1'b0;
        dwt_result = 1'b0;
        dwt_s = 8'h00;
        dwt_d = 8'h00;
        forever begin
            @(negedge clk);
            n_res = 1'b0;
            n_s = 8'h00;
            n_d = 8'h00;
            if (!resetn) begin
                m_ph = PH_IDLE;
                m_band = 0;
                m_cnt = 0;
                n_rdy = 1'b1;
            end else begin
                case (m_ph)
                    PH_IDLE: begin
                        if (dwt_en) begin
                            n_en_seen++;
                            if (m_band == 0) chk("en_no_gap_cycle", 64'(cyc), 64'(start_cyc + 1));
                            m_n = (m_band == 0) ? 24 : ((m_band == 3) ? 8 : 16);
                            m_cnt = 0;
                            m_ph = PH_FEED;
                            n_rdy = 1'b0;
                        end
                    end
                    PH_FEED: begin
                        if (feed_q.size() == 0) fail("feed_unexpected_sample");
                        else chk("feed_sample", 64'(dwt_in), 64'(feed_q.pop_front()));
                        m_cnt++;
                        if (m_cnt == m_n) begin
                            m_cnt = 0;
                            if (cfg_lat == 0) begin
                                n_res = 1'b1;
                                m_ph = PH_OUT;
                            end else begin
                                m_ph = PH_LAT;
                            end
                        end else if (cfg_spur && m_cnt == 3) begin
                            n_res = 1'b1;
                        end
                    end
                    PH_LAT: begin
                        chk("we_during_latency", 64'(dst_we), 64'(0));
                        m_cnt++;
                        if (m_cnt == cfg_lat) begin
                            n_res = 1'b1;
                            m_ph = PH_OUT;
                            m_cnt = 0;
                        end
                    end
                    PH_OUT: begin
                        if (m_cnt == 0) chk("we_on_result_cycle", 64'(dst_we), 64'(0));
                        else chk("we_in_drain", 64'(dst_we), 64'(1));
                        if (m_cnt < 8) begin
                            n_s = 8'(m_cnt);
                            n_d = 8'(128 + m_band);
                            m_cnt++;
                        end else begin
                            m_ph = PH_POST;
                        end
                    end
                    PH_POST: begin
                        chk("we_after_drain", 64'(dst_we), 64'(0));
                        if (m_band == 3) begin
                            m_band = 0;
                            n_rdy = 1'b1;
                            m_ph = PH_IDLE;
                        end else begin
                            m_band++;
                            if (m_band == cfg_stall_band) begin
                                stall_addr = src_addr;
                                m_cnt = 0;
                                m_ph = PH_STALL;
                            end else begin
                                n_rdy = 1'b1;
                                m_ph = PH_IDLE;
                            end
                        end
                    end
                    PH_STALL: begin
                        chk("stall_src_addr", 64'(src_addr), 64'(stall_addr));
                        chk("stall_en", 64'(dwt_en), 64'(0));
                        chk("stall_we", 64'(dst_we), 64'(0));
                        m_cnt++;
                        if (m_cnt == 20) begin
                            n_rdy = 1'b1;
                            m_ph = PH_IDLE;
                        end
                    end
                    default: m_ph = PH_IDLE;
                endcase
            end
            @(posedge clk);
            #1;
            dwt_rdy = n_rdy;
            dwt_result = n_res;
            dwt_s = n_s;
            dwt_d = n_d;
        end
    end

    // Scoreboard monitor for destination writes and done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (dst_we) begin
                    n_we++;
                    if (exp_q.size() == 0) fail("dst_we_unexpected");
                    else chk("dst_write", 64'({dst_s_addr, dst_d_addr, dst_s_data, dst_d_data}),
                             64'(exp_q.pop_front()));
                end
                if (done) begin
                    done_seen++;
                    if (exp_done == 0) fail("done_unexpected");
                    else exp_done--;
                    chk("busy_at_done", 64'(busy), 64'(1));
                end
            end
        end
    end

    task automatic push_frame();
        for (int p = 0; p < 64; p++) feed_q.push_back(8'(p));
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back({16'(b * 8 + j), 16'((b + 4) * 8 + j), 8'(j), 8'(128 + b)});
            end
        end
        exp_done++;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic run_frame(input int stall_band, input int lat, input bit spur, input bit extra);
        int d0;
        int en0;
        int we0;
        int t;
        bit sent;
        cfg_stall_band = stall_band;
        cfg_lat = lat;
        cfg_spur = spur;
        push_frame();
        d0 = done_seen;
        en0 = n_en_seen;
        we0 = n_we;
        pulse_start();
        t = 0;
        sent = 1'b0;
        while (done_seen == d0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            start = 1'b0;
            if (extra && !sent && m_band == 1) begin
                start = 1'b1;
                sent = 1'b1;
            end
        end
        start = 1'b0;
        if (t >= 3000) fail("done_timeout");
        chk("busy_after_done", 64'(busy), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("en_count", 64'(n_en_seen - en0), 64'(4));
        chk("we_count", 64'(n_we - we0), 64'(32));
        chk("done_count", 64'(done_seen - d0), 64'(1));
        chk("feed_left", 64'(feed_q.size()), 64'(0));
        chk("writes_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_ctrl"}, 64'({done, dwt_en, dst_we}), 64'(0));
        chk({nm, "_src_addr"}, 64'(src_addr), 64'(0));
        chk({nm, "_dwt_in"}, 64'(dwt_in), 64'(0));
        chk({nm, "_dst"}, 64'({dst_s_addr, dst_d_addr, dst_s_data, dst_d_data}), 64'(0));
    endtask

    initial begin
        int t;
        int d0;
        resetn = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(99, 0, 1'b0, 1'b0);
        run_frame(2, 0, 1'b0, 1'b0);
        run_frame(99, 50, 1'b1, 1'b0);
        run_frame(99, 3, 1'b0, 1'b1);

        // Abandon a frame with an asynchronous reset at band 2, sample 5.
        cfg_stall_band = 99;
        cfg_lat = 0;
        cfg_spur = 1'b0;
        push_frame();
        d0 = done_seen;
        pulse_start();
        t = 0;
        while (!(m_ph == PH_FEED && m_band == 2 && m_cnt == 5) && t < 3000) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 3000) fail("reset_point_timeout");
        resetn = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        feed_q.delete();
        exp_q.delete();
        exp_done = 0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_seen), 64'(d0));
        chk("idle_after_reset", 64'({busy, dst_we}), 64'(0));

        run_frame(99, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
